// File: rtl/rtc_write_sequencer.sv
// Write-request sequencer for the RTC: arbitrates time/date/timer groups, snapshots
// their three bytes and feeds them one by one to the register-write FSM.
module rtc_write_sequencer #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_hora,
  input  logic       req_fecha,
  input  logic       req_timer,
  input  logic [7:0] seg,
  input  logic [7:0] min,
  input  logic [7:0] hora,
  input  logic [7:0] dia,
  input  logic [7:0] mes,
  input  logic [7:0] anio,
  input  logic [7:0] t0,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  input  logic       clr_err,
  input  logic       wr_final,
  output logic       iniciar,
  output logic [7:0] dir,
  output logic [7:0] dato,
  output logic       busy,
  output logic       done_hora,
  output logic       done_fecha,
  output logic       done_timer,
  output logic       err
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DONE, ABORT} state_t;

  // grp is one-hot: [0] hora, [1] fecha, [2] timer
  typedef struct packed {
    logic [2:0]      grp;
    logic [2:0][7:0] b;
  } snap_t;

  state_t     state_q, state_d;
  snap_t      snap_q, snap_d;
  logic [2:0] pend_q, pend_d, req_v, win;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [9:0] to_q, to_d;
  logic       err_q, err_d;
  logic [7:0] base;

  assign req_v = {req_timer, req_fecha, req_hora};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      pend_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    pend_d  = pend_q | req_v;
    idx_d   = idx_q;
    gap_d   = '0;
    to_d    = '0;
    err_d   = err_q & ~clr_err;
    win     = pend_q[0] ? 3'b001 : pend_q[1] ? 3'b010 : pend_q[2] ? 3'b100 : 3'b000;
    case (state_q)
      IDLE: if (|pend_q) begin
        // a fresh request for the winner in this same cycle keeps it pending
        pend_d     = (pend_q & ~win) | req_v;
        snap_d.grp = win;
        snap_d.b   = win[0] ? {hora, min, seg} : win[1] ? {anio, mes, dia} : {t2, t1, t0};
        idx_d      = '0;
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (wr_final) state_d = GAP;
        else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end else to_d = to_q + 10'd1;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q == 2'd2) state_d = DONE;
          else begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end else gap_d = gap_q + 4'd1;
      end
      DONE:  state_d = IDLE;
      ABORT: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base = snap_q.grp[0] ? 8'h21 : snap_q.grp[1] ? 8'h24 : snap_q.grp[2] ? 8'h41 : 8'h00;
    iniciar = (state_q == ISSUE);
    dir     = '0;
    dato    = '0;
    // address/data held from ISSUE through DONE so they never change under iniciar
    if (state_q == ISSUE || state_q == GAP || state_q == DONE) begin
      dir = base + {6'd0, idx_q};
      case (idx_q)
        2'd0:    dato = snap_q.b[0];
        2'd1:    dato = snap_q.b[1];
        default: dato = snap_q.b[2];
      endcase
    end
  end

  assign busy       = (state_q != IDLE) | (|pend_q);
  assign done_hora  = (state_q == DONE) & snap_q.grp[0];
  assign done_fecha = (state_q == DONE) & snap_q.grp[1];
  assign done_timer = (state_q == DONE) & snap_q.grp[2];
  assign err        = err_q;

endmodule
